digct_stim_checker: RTL and testbench

- Self-checking stimulus driver for the registered 5-input/3-output logic cell DigCt.
- Drives all 32 combinations of IN1..IN5, samples the cell's registered OUT1..OUT3 after the pipeline latency and compares them against an internal golden model.
- Reports a mismatch count, the first failing pattern, and PASS/DONE status.
- Sits beside the cell in bring-up and BIST wrappers.

---
 rtl/digct_stim_checker.sv | 209 ++++++++++++++++++++
 tb/tb_digct_stim_checker.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digct_stim_checker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// digct_stim_checker
//
// Purpose:
//    Self-checking stimulus driver for the registered 5-input / 3-output
//    logic cell DigCt. A run walks the pattern P through all 32 values of
//    IN1..IN5. Each pattern is held for LATENCY+1 cycles. On the last cycle
//    of each hold, the cell's registered outputs are compared against an
//    internal golden model. Any pattern with at least one differing output
//    bit counts as one error.
//
// Parameters:
//    LATENCY        cell register stages between IN* and OUT* (1..4)
//    ERR_W          width of ERR_CNT; the counter saturates at all-ones
//
// Ports:
//    CLK            rising-edge clock shared with the cell
//    RST            asynchronous reset, active-high
//    START          begin a run (honoured in IDLE or DONE only)
//    ABORT          terminate a run / leave DONE, return to IDLE
//    IN1..IN5       stimulus to the cell, IN1 = P[0] ... IN5 = P[4]
//    DUT_OUT1..3    the cell's registered outputs OUT1..OUT3
//    BUSY           run in progress
//    DONE           run completed, held until next START, ABORT or reset
//    PASS           meaningful while DONE; 1 when no pattern mismatched
//    ERR_CNT        number of mismatching patterns, saturating
//    FIRST_FAIL     pattern P of the first mismatch
//    FIRST_FAIL_VLD FIRST_FAIL holds a captured value
// ---------------------------------------------------------------------------
module digct_stim_checker #(
   parameter int LATENCY = 1,
   parameter int ERR_W   = 6
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic             ABORT,
   output logic             IN1,
   output logic             IN2,
   output logic             IN3,
   output logic             IN4,
   output logic             IN5,
   input  logic             DUT_OUT1,
   input  logic             DUT_OUT2,
   input  logic             DUT_OUT3,
   output logic             BUSY,
   output logic             DONE,
   output logic             PASS,
   output logic [ERR_W-1:0] ERR_CNT,
   output logic [4:0]       FIRST_FAIL,
   output logic             FIRST_FAIL_VLD
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // A three-bit hold counter covers the whole legal LATENCY range (1..4).
   localparam logic [2:0]       HOLD_LAST = 3'(LATENCY);
   localparam logic [4:0]       P_LAST    = 5'd31;
   localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

   state_t           state_q, state_d;
   logic [4:0]       p_q, p_d;
   logic [2:0]       hold_q, hold_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
   logic [4:0]       first_fail_q, first_fail_d;
   logic             first_fail_vld_q, first_fail_vld_d;

   logic [2:0]       expected;
   logic [2:0]       observed;
   logic             mismatch;
   logic [ERR_W-1:0] err_cnt_inc;
   logic [ERR_W-1:0] err_cnt_next;

   // Golden model of the DigCt cell, evaluated on the pattern currently
   // being driven. Bit 0 is OUT1, bit 2 is OUT3.
   always_comb begin
      expected[0] = ~(~(p_q[0] | p_q[1]) & p_q[2]);
      expected[1] = ~(p_q[1] & p_q[2]);
      expected[2] = p_q[2] | ~p_q[3] | p_q[4];
   end

   // Compare outcome and the saturating error count that would result
   // from a compare in this cycle. Only used when the hold has elapsed.
   always_comb begin
      observed     = {DUT_OUT3, DUT_OUT2, DUT_OUT1};
      mismatch     = (observed != expected);
      err_cnt_inc  = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_W'(1);
      err_cnt_next = mismatch ? err_cnt_inc : err_cnt_q;
   end

   // Next-state and result logic. ABORT is examined before START and
   // before any compare so that it always wins. Starting a run clears
   // every result register; aborting a run keeps ERR_CNT and FIRST_FAIL
   // so the partial outcome can still be inspected.
   always_comb begin
      state_d          = state_q;
      p_d              = p_q;
      hold_d           = hold_q;
      busy_d           = busy_q;
      done_d           = done_q;
      pass_d           = pass_q;
      err_cnt_d        = err_cnt_q;
      first_fail_d     = first_fail_q;
      first_fail_vld_d = first_fail_vld_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (ABORT) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (START) begin
               state_d          = ST_RUN;
               p_d              = 5'd0;
               hold_d           = 3'd0;
               busy_d           = 1'b1;
               done_d           = 1'b0;
               pass_d           = 1'b0;
               err_cnt_d        = '0;
               first_fail_d     = 5'd0;
               first_fail_vld_d = 1'b0;
            end
         end

         ST_RUN: begin
            if (ABORT) begin
               state_d = ST_IDLE;
               p_d     = 5'd0;
               hold_d  = 3'd0;
               busy_d  = 1'b0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (hold_q < HOLD_LAST) begin
               hold_d = hold_q + 3'd1;
            end else begin
               err_cnt_d = err_cnt_next;
               if (mismatch && !first_fail_vld_q) begin
                  first_fail_d     = p_q;
                  first_fail_vld_d = 1'b1;
               end
               hold_d = 3'd0;
               if (p_q != P_LAST) begin
                  p_d = p_q + 5'd1;
               end else begin
                  state_d = ST_DONE;
                  p_d     = 5'd0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_cnt_next == '0);
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and result registers. Reset is asynchronous so that a reset
   // pulse mid-run clears the stimulus and results without waiting for
   // a clock edge.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q          <= ST_IDLE;
         p_q              <= 5'd0;
         hold_q           <= 3'd0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
         err_cnt_q        <= '0;
         first_fail_q     <= 5'd0;
         first_fail_vld_q <= 1'b0;
      end else begin
         state_q          <= state_d;
         p_q              <= p_d;
         hold_q           <= hold_d;
         busy_q           <= busy_d;
         done_q           <= done_d;
         pass_q           <= pass_d;
         err_cnt_q        <= err_cnt_d;
         first_fail_q     <= first_fail_d;
         first_fail_vld_q <= first_fail_vld_d;
      end
   end

   // Every output comes straight from a register. The stimulus lines are
   // the bits of the pattern, which is held at zero outside a run.
   assign IN1            = p_q[0];
   assign IN2            = p_q[1];
   assign IN3            = p_q[2];
   assign IN4            = p_q[3];
   assign IN5            = p_q[4];
   assign BUSY           = busy_q;
   assign DONE           = done_q;
   assign PASS           = pass_q;
   assign ERR_CNT        = err_cnt_q;
   assign FIRST_FAIL     = first_fail_q;
   assign FIRST_FAIL_VLD = first_fail_vld_q;

endmodule

// File: tb/tb_digct_stim_checker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_digct_stim_checker
//
// Three checkers, each paired with a behavioural DigCt cell:
//    A: LATENCY=1, cell depth selectable 1 or 3, optional OUT2 stuck-at-1
//    B: LATENCY=3, 3-stage cell
//    C: LATENCY=1, ERR_W=2, cell with every output inverted
// Expected end-of-run results are pushed into a per-checker queue when a
// run is started; a monitor pops and compares when DONE rises.
// ---------------------------------------------------------------------------
module tb_digct_stim_checker;

   typedef struct {
      int lat;
      int pass;
      int err;
      int ff;
      int vld;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0, abort_a = 1'b0;
   logic start_b = 1'b0, abort_b = 1'b0;
   logic start_c = 1'b0, abort_c = 1'b0;
   logic fault_out2 = 1'b0;
   logic depth3 = 1'b0;

   wire [4:0] in_a, in_b, in_c;
   wire [2:0] cell_out_a, cell_out_b;
   logic [2:0] cell_out_c = 3'b000;
   logic [2:0] a_s1 = 3'b000, a_s2 = 3'b000, a_s3 = 3'b000;
   logic [2:0] b_s1 = 3'b000, b_s2 = 3'b000, b_s3 = 3'b000;

   wire busy_a, done_a, pass_a, ffvld_a;
   wire busy_b, done_b, pass_b, ffvld_b;
   wire busy_c, done_c, pass_c, ffvld_c;
   wire [5:0] err_a, err_b;
   wire [1:0] err_c;
   wire [4:0] ff_a, ff_b, ff_c;
   wire [19:0] outs_a = {in_a, busy_a, done_a, pass_a, err_a, ff_a, ffvld_a};
   wire [19:0] outs_b = {in_b, busy_b, done_b, pass_b, err_b, ff_b, ffvld_b};
   wire [15:0] outs_c = {in_c, busy_c, done_c, pass_c, err_c, ff_c, ffvld_c};

   int cyc = 0;
   int t0_a = 0, t0_b = 0, t0_c = 0;
   int n_checks = 0;
   int n_fail = 0;
   exp_t q_a[$], q_b[$], q_c[$];
   exp_t e_a, e_b, e_c;
   logic done_a_prev = 1'b0, done_b_prev = 1'b0, done_c_prev = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural DigCt: {OUT3, OUT2, OUT1}
   function automatic logic [2:0] cell_fn(input logic [4:0] p);
      logic [2:0] r;
      r[0] = ~(~(p[0] | p[1]) & p[2]);
      r[1] = ~(p[1] & p[2]);
      r[2] = p[2] | ~p[3] | p[4];
      return r;
   endfunction

   always @(posedge clk) begin
      a_s1 <= cell_fn(in_a);
      a_s2 <= a_s1;
      a_s3 <= a_s2;
      b_s1 <= cell_fn(in_b);
      b_s2 <= b_s1;
      b_s3 <= b_s2;
      cell_out_c <= ~cell_fn(in_c);
   end

   assign cell_out_a = (depth3 ? a_s3 : a_s1) | (fault_out2 ? 3'b010 : 3'b000);
   assign cell_out_b = b_s3;

   digct_stim_checker #(.LATENCY(1), .ERR_W(6)) dut_a (
      .CLK(clk), .RST(rst), .START(start_a), .ABORT(abort_a),
      .IN1(in_a[0]), .IN2(in_a[1]), .IN3(in_a[2]), .IN4(in_a[3]), .IN5(in_a[4]),
      .DUT_OUT1(cell_out_a[0]), .DUT_OUT2(cell_out_a[1]), .DUT_OUT3(cell_out_a[2]),
      .BUSY(busy_a), .DONE(done_a), .PASS(pass_a), .ERR_CNT(err_a),
      .FIRST_FAIL(ff_a), .FIRST_FAIL_VLD(ffvld_a)
   );

   digct_stim_checker #(.LATENCY(3), .ERR_W(6)) dut_b (
      .CLK(clk), .RST(rst), .START(start_b), .ABORT(abort_b),
      .IN1(in_b[0]), .IN2(in_b[1]), .IN3(in_b[2]), .IN4(in_b[3]), .IN5(in_b[4]),
      .DUT_OUT1(cell_out_b[0]), .DUT_OUT2(cell_out_b[1]), .DUT_OUT3(cell_out_b[2]),
      .BUSY(busy_b), .DONE(done_b), .PASS(pass_b), .ERR_CNT(err_b),
      .FIRST_FAIL(ff_b), .FIRST_FAIL_VLD(ffvld_b)
   );

   digct_stim_checker #(.LATENCY(1), .ERR_W(2)) dut_c (
      .CLK(clk), .RST(rst), .START(start_c), .ABORT(abort_c),
      .IN1(in_c[0]), .IN2(in_c[1]), .IN3(in_c[2]), .IN4(in_c[3]), .IN5(in_c[4]),
      .DUT_OUT1(cell_out_c[0]), .DUT_OUT2(cell_out_c[1]), .DUT_OUT3(cell_out_c[2]),
      .BUSY(busy_c), .DONE(done_c), .PASS(pass_c), .ERR_CNT(err_c),
      .FIRST_FAIL(ff_c), .FIRST_FAIL_VLD(ffvld_c)
   );

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic scoreCheck(input string tag, input exp_t e, input int lat, input int pass,
                             input int err, input int ff, input int vld, input int busy);
      checkOutput({tag, "_done_latency"}, lat, e.lat);
      checkOutput({tag, "_pass"}, pass, e.pass);
      checkOutput({tag, "_err_cnt"}, err, e.err);
      checkOutput({tag, "_first_fail"}, ff, e.ff);
      checkOutput({tag, "_first_fail_vld"}, vld, e.vld);
      checkOutput({tag, "_busy_at_done"}, busy, 0);
   endtask

   function automatic exp_t mk(input int lat, input int pass, input int err, input int ff, input int vld);
      exp_t e;
      e.lat  = lat;
      e.pass = pass;
      e.err  = err;
      e.ff   = ff;
      e.vld  = vld;
      return e;
   endfunction

   function automatic logic getDone(input int which);
      case (which)
         0:       return done_a;
         1:       return done_b;
         default: return done_c;
      endcase
   endfunction

   // Monitors: one per checker, popping the scoreboard when DONE rises.
   always @(negedge clk) begin
      if (done_a && !done_a_prev) begin
         if (q_a.size() == 0) checkOutput("A_done_expected", q_a.size(), 1);
         else begin
            e_a = q_a.pop_front();
            scoreCheck("A", e_a, cyc - t0_a, pass_a, err_a, ff_a, ffvld_a, busy_a);
         end
      end
      done_a_prev = done_a;
   end

   always @(negedge clk) begin
      if (done_b && !done_b_prev) begin
         if (q_b.size() == 0) checkOutput("B_done_expected", q_b.size(), 1);
         else begin
            e_b = q_b.pop_front();
            scoreCheck("B", e_b, cyc - t0_b, pass_b, err_b, ff_b, ffvld_b, busy_b);
         end
      end
      done_b_prev = done_b;
   end

   always @(negedge clk) begin
      if (done_c && !done_c_prev) begin
         if (q_c.size() == 0) checkOutput("C_done_expected", q_c.size(), 1);
         else begin
            e_c = q_c.pop_front();
            scoreCheck("C", e_c, cyc - t0_c, pass_c, err_c, ff_c, ffvld_c, busy_c);
         end
      end
      done_c_prev = done_c;
   end

   // Called at a falling edge; returns at the falling edge right after the
   // START edge (cycle 0 of the run).
   task automatic applyStimulus(input int which, input bit push, input exp_t e);
      if (push) begin
         case (which)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
         endcase
      end
      case (which)
         0:       start_a = 1'b1;
         1:       start_b = 1'b1;
         default: start_c = 1'b1;
      endcase
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      start_c = 1'b0;
      case (which)
         0:       t0_a = cyc;
         1:       t0_b = cyc;
         default: t0_c = cyc;
      endcase
   endtask

   task automatic waitDone(input int which, input int budget, input string name);
      int n = 0;
      while (!getDone(which) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, getDone(which), 1);
   endtask

   task automatic waitInA(input int value, input int budget, input string name);
      int n = 0;
      while (int'(in_a) != value && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(name, in_a, value);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("A_reset_outputs", outs_a, 0);
      checkOutput("B_reset_outputs", outs_b, 0);
      checkOutput("C_reset_outputs", outs_c, 0);
      rst = 1'b0;
      @(negedge clk);
      checkOutput("A_idle_outputs", outs_a, 0);

      // Healthy cell: P steps 0..31, two cycles each
      applyStimulus(0, 1'b1, mk(64, 1, 0, 0, 0));
      for (int c = 0; c < 64; c++) begin
         checkOutput($sformatf("A_step_c%0d", c), in_a, c / 2);
         checkOutput($sformatf("A_busy_c%0d", c), busy_a, 1);
         if (c == 9) begin
            checkOutput("spot_p00100_cell", cell_out_a, 3'b110);
            checkOutput("spot_p00100_err", err_a, 0);
         end
         if (c == 13) begin
            checkOutput("spot_p00110_cell", cell_out_a, 3'b101);
            checkOutput("spot_p00110_err", err_a, 0);
         end
         @(negedge clk);
      end
      waitDone(0, 4, "A_run1_done");
      repeat (3) @(negedge clk);
      checkOutput("A_done_held", done_a, 1);
      checkOutput("A_done_pass_held", pass_a, 1);
      checkOutput("A_done_in_zero", in_a, 0);

      // OUT2 stuck-at-1: fails where P1&P2
      fault_out2 = 1'b1;
      applyStimulus(0, 1'b1, mk(64, 0, 8, 6, 1));
      checkOutput("A_restart_done_drop", done_a, 0);
      checkOutput("A_restart_busy", busy_a, 1);
      waitDone(0, 80, "A_stuck_done");

      // ABORT at P=10 (errors at 6,7 already counted)
      repeat (2) @(negedge clk);
      applyStimulus(0, 1'b0, mk(0, 0, 0, 0, 0));
      waitInA(10, 40, "A_reach_p10");
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      checkOutput("abort_busy", busy_a, 0);
      checkOutput("abort_done", done_a, 0);
      checkOutput("abort_in", in_a, 0);
      checkOutput("abort_pass", pass_a, 0);
      checkOutput("abort_err_kept", err_a, 2);
      checkOutput("abort_ff_kept", ff_a, 6);
      checkOutput("abort_ffvld_kept", ffvld_a, 1);
      repeat (3) @(negedge clk);
      checkOutput("abort_stays_idle", busy_a, 0);
      checkOutput("abort_err_still", err_a, 2);
      fault_out2 = 1'b0;
      applyStimulus(0, 1'b1, mk(64, 1, 0, 0, 0));
      waitDone(0, 80, "A_after_abort_done");

      // START and ABORT together in DONE: ABORT wins
      start_a = 1'b1;
      abort_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      abort_a = 1'b0;
      checkOutput("startabort_busy", busy_a, 0);
      checkOutput("startabort_done", done_a, 0);
      checkOutput("startabort_pass", pass_a, 0);
      @(negedge clk);
      checkOutput("startabort_idle", busy_a, 0);

      // Asynchronous reset mid-run at P=17
      fault_out2 = 1'b1;
      applyStimulus(0, 1'b0, mk(0, 0, 0, 0, 0));
      waitInA(17, 80, "A_reach_p17");
      checkOutput("pre_reset_err", err_a, 4);
      #2 rst = 1'b1;
      #1 checkOutput("async_reset_outputs", outs_a, 0);
      @(negedge clk);
      rst = 1'b0;
      checkOutput("reset_release_outputs", outs_a, 0);
      fault_out2 = 1'b0;
      applyStimulus(0, 1'b1, mk(64, 1, 0, 0, 0));
      checkOutput("restart_p_c0", in_a, 0);
      checkOutput("restart_busy_c0", busy_a, 1);
      @(negedge clk);
      checkOutput("restart_p_c1", in_a, 0);
      @(negedge clk);
      checkOutput("restart_p_c2", in_a, 1);
      waitDone(0, 80, "A_after_reset_done");

      // LATENCY=1 checker against a 3-stage cell: sees f(P-1) for P
      depth3 = 1'b1;
      repeat (4) @(negedge clk);
      applyStimulus(0, 1'b1, mk(64, 0, 15, 4, 1));
      waitDone(0, 80, "A_depth3_done");
      depth3 = 1'b0;

      // LATENCY=3 checker with matching cell; saturating ERR_W=2 checker
      applyStimulus(1, 1'b1, mk(128, 1, 0, 0, 0));
      applyStimulus(2, 1'b1, mk(64, 0, 3, 0, 1));
      waitDone(2, 80, "C_sat_done");
      waitDone(1, 160, "B_lat3_done");

      repeat (2) @(negedge clk);
      checkOutput("A_queue_drained", q_a.size(), 0);
      checkOutput("B_queue_drained", q_b.size(), 0);
      checkOutput("C_queue_drained", q_c.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
